// File: rtl/dp_seq_pkg.sv
// rtl/dp_seq_pkg.sv - shared types and widths for the datapath sequencer
//
// Purpose: FSM state encoding and datapath widths used by dp_seq_ctrl and
// dp_seq_rr_arb. No ports.
package dp_seq_pkg;

   localparam int DP_IN_W  = 4;
   localparam int DP_OUT_W = 38;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dp_seq_rr_arb.sv
// rtl/dp_seq_rr_arb.sv - combinational round-robin arbiter
//
// Purpose: picks the first asserted requester found by searching upward from
// last_grant+1, wrapping modulo NUM_REQ.
// Ports:
//   req_valid   in   NUM_REQ  per-requester request
//   last_grant  in   ID_W     index granted most recently
//   grant       out  NUM_REQ  one-hot grant, zero when nothing is valid
//   grant_idx   out  ID_W     encoded grant index
//   any_valid   out  1        at least one request is asserted
module dp_seq_rr_arb
   import dp_seq_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_valid
);

   logic [ID_W-1:0] idx;

   // Offsets run 1..NUM_REQ so last_grant itself is visited last; this is
   // what lets a lone persistent requester win every time.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
         if (!any_valid && req_valid[idx]) begin
            any_valid   = 1'b1;
            grant[idx]  = 1'b1;
            grant_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/dp_seq_ctrl.sv
// rtl/dp_seq_ctrl.sv - sequencer sharing one combinational datapath among requesters
//
// Purpose: accepts one 4-bit operand at a time (round-robin among NUM_REQ
// requesters), drives it registered into an external combinational datapath,
// captures the 38-bit result after the evaluation window and returns it with
// the owning requester id.
// Optional feature: define DPSEQ_MULTICYCLE_EN to stretch the evaluation
// window to EVAL_CYCLES cycles; otherwise it lasts exactly one cycle.
// Ports:
//   clk          in   1           clock, rising edge
//   rst          in   1           asynchronous active-high reset
//   req_valid    in   NUM_REQ     per-requester operand valid
//   req_data     in   4*NUM_REQ   operand i in bits [4i+3:4i]
//   req_ready    out  NUM_REQ     one-hot accept strobe, or zero
//   dp_in_data   out  4           registered operand to the datapath
//   dp_out_data  in   38          datapath result
//   rsp_valid    out  1           result valid
//   rsp_ready    in   1           result consumer ready
//   rsp_data     out  38          captured result
//   rsp_id       out  ID_W        requester owning rsp_data
//   busy         out  1           high whenever not idle
module dp_seq_ctrl
   import dp_seq_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int EVAL_CYCLES = 2,
   localparam int ID_W        = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [DP_IN_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [DP_IN_W-1:0]         dp_in_data,
   input  logic [DP_OUT_W-1:0]        dp_out_data,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DP_OUT_W-1:0]        rsp_data,
   output logic [ID_W-1:0]            rsp_id,
   output logic                       busy
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_EVAL = EVAL;
   localparam logic [1:0] ST_RESP = RESP;

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("dp_seq_ctrl: NUM_REQ must be 2..16");
   end
   if (EVAL_CYCLES < 1 || EVAL_CYCLES > 15) begin : g_bad_eval_cycles
      $error("dp_seq_ctrl: EVAL_CYCLES must be 1..15");
   end

   logic [1:0]          state;
   logic [ID_W-1:0]     last_grant;
   logic [ID_W-1:0]     id_q;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic                any_valid;
   logic [DP_IN_W-1:0]  sel_data;
   logic                eval_done;

   dp_seq_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any_valid  (any_valid)
   );

   assign sel_data  = req_data[grant_idx*DP_IN_W +: DP_IN_W];
   // Accept strobe is only offered while idle; requests seen in other states
   // simply wait for the next IDLE cycle.
   assign req_ready = (state == ST_IDLE) ? grant : '0;
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);

`ifdef DPSEQ_MULTICYCLE_EN
   logic [3:0] eval_cnt;

   // Loaded on the accept edge so the first EVAL cycle already sees
   // EVAL_CYCLES-1; capture happens once it reaches zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eval_cnt <= 4'd0;
      end else if (state == ST_IDLE && any_valid) begin
         eval_cnt <= 4'(EVAL_CYCLES - 1);
      end else if (state == ST_EVAL && eval_cnt != 4'd0) begin
         eval_cnt <= eval_cnt - 4'd1;
      end
   end

   assign eval_done = (eval_cnt == 4'd0);
`else
   assign eval_done = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= ID_W'(NUM_REQ - 1);
         id_q       <= '0;
         dp_in_data <= '0;
         rsp_data   <= '0;
         rsp_id     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  dp_in_data <= sel_data;
                  id_q       <= grant_idx;
                  last_grant <= grant_idx;
                  state      <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (eval_done) begin
                  rsp_data <= dp_out_data;
                  rsp_id   <= id_q;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dp_seq_ctrl.sv
// tb/tb_dp_seq_ctrl.sv - scoreboard bench for dp_seq_ctrl
module tb_dp_seq_ctrl;

   localparam int N   = 4;
   localparam int IDW = 2;
`ifdef DPSEQ_MULTICYCLE_EN
   localparam int E = 3;
`else
   localparam int E = 1;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid;
   logic [4*N-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic [3:0]     dp_in_data;
   logic [37:0]    dp_out_data;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [37:0]    rsp_data;
   logic [IDW-1:0] rsp_id;
   logic           busy;

   always #5 clk = ~clk;

   dp_seq_ctrl #(
      .NUM_REQ     (N),
      .EVAL_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .dp_in_data  (dp_in_data),
      .dp_out_data (dp_out_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_id      (rsp_id),
      .busy        (busy)
   );

   // Datapath model: x3, with an all-ones glitch while the window is still open.
   logic glitch = 1'b0;
   assign dp_out_data = glitch ? {38{1'b1}} : (38'(dp_in_data) * 38'd3);

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          id;
      logic [37:0] data;
      int          acc;
   } exp_t;

   exp_t q[$];

   // Reference model: free / evaluating for E cycles / holding a response.
   int         m_phase = 0;
   int         m_left  = 0;
   int         m_last  = N - 1;
   logic [3:0] m_op    = 4'd0;

   always @(negedge clk) begin
      int g;
      int idx;
      if (rst) begin
         m_phase = 0;
         m_last  = N - 1;
         q.delete();
         glitch  = 1'b0;
         check("rst_req_ready", 64'(req_ready), 64'd0);
         check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_dp_in", 64'(dp_in_data), 64'd0);
         check("rst_rsp_data", 64'(rsp_data), 64'd0);
         check("rst_rsp_id", 64'(rsp_id), 64'd0);
      end else begin
         case (m_phase)
            0: begin
               check("idle_busy", 64'(busy), 64'd0);
               g = -1;
               for (int k = 1; k <= N; k++) begin
                  idx = (m_last + k) % N;
                  if (g < 0 && req_valid[idx]) g = idx;
               end
               check("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
               if (g >= 0) begin
                  m_op = req_data[4*g +: 4];
                  q.push_back('{g, 38'(m_op) * 38'd3, cyc});
                  m_last  = g;
                  m_phase = 1;
                  m_left  = E;
               end
            end
            1: begin
               check("eval_req_ready", 64'(req_ready), 64'd0);
               check("eval_busy", 64'(busy), 64'd1);
               check("eval_rsp_valid", 64'(rsp_valid), 64'd0);
               check("eval_dp_in", 64'(dp_in_data), 64'(m_op));
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
            default: begin
               check("resp_req_ready", 64'(req_ready), 64'd0);
               check("resp_busy", 64'(busy), 64'd1);
               check("resp_rsp_valid", 64'(rsp_valid), 64'd1);
               if (rsp_ready) m_phase = 0;
            end
         endcase
         glitch = (m_phase == 1);
      end
   end

   // Monitor: compares every presented response against the scoreboard head.
   bit seen = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         seen = 1'b0;
      end else if (rsp_valid) begin
         if (q.size() == 0) begin
            check("rsp_unexpected", 64'(rsp_valid), 64'd0);
         end else begin
            if (!seen) begin
               check("rsp_latency", 64'(cyc), 64'(q[0].acc + E + 1));
               seen = 1'b1;
            end
            check("rsp_data", 64'(rsp_data), 64'(q[0].data));
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            if (rsp_ready) begin
               void'(q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // Stimulus helpers
   logic [N-1:0] acc;

   task automatic step();
      @(negedge clk);
      acc = req_ready & req_valid & {N{~rst}};
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [3:0] op);
      req_valid[i]      = 1'b1;
      req_data[4*i +: 4] = op;
   endtask

   task automatic wait_accept(input int i);
      bit got;
      got = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         step();
         if (acc[i]) got = 1'b1;
      end
      if (!got) check("accept_timeout", 64'(acc[i]), 64'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && req_valid != '0; t++) begin
         step();
         req_valid &= ~acc;
      end
      if (req_valid != '0) check("drain_timeout", 64'(req_valid), 64'd0);
   endtask

   initial begin
      int accepts;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();
      step();

      // single request from requester 2, operand 5
      set_req(2, 4'h5);
      wait_accept(2);
      req_valid[2] = 1'b0;
      repeat (6) step();

      // max operand, exercises the glitch when the window is multi-cycle
      set_req(0, 4'hF);
      wait_accept(0);
      req_valid[0] = 1'b0;
      repeat (8) step();

      // round-robin from a fresh reset, all requesters continuously valid
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 4'(i + 1));
      accepts = 0;
      for (int t = 0; t < 100 && accepts < 5; t++) begin
         step();
         if (acc != '0) accepts++;
      end
      drain();
      repeat (6) step();

      // backpressure: response held for more than 10 cycles
      rsp_ready = 1'b0;
      set_req(1, 4'h7);
      set_req(3, 4'hA);
      wait_accept(1);
      req_valid[1] = 1'b0;
      repeat (14) step();
      rsp_ready = 1'b1;
      drain();
      repeat (6) step();

      // reset in the middle of the evaluation window
      set_req(3, 4'h9);
      wait_accept(3);
      req_valid[3] = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 4'($urandom_range(0, 15)));
      drain();
      repeat (6) step();

      // randomized traffic
      for (int t = 0; t < 400; t++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
               else set_req(i, 4'($urandom_range(0, 15)));
            end else if (!req_valid[i] && $urandom_range(0, 99) < 30) begin
               set_req(i, 4'($urandom_range(0, 15)));
            end
         end
         rsp_ready = ($urandom_range(0, 99) < 70);
      end
      rsp_ready = 1'b1;
      drain();
      for (int t = 0; t < 50 && (q.size() != 0 || m_phase != 0); t++) step();
      check("final_queue_empty", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dp_seq_ctrl.md
# dp_seq_ctrl

Sequencer and round-robin arbiter that shares one combinational 4-bit→38-bit arithmetic datapath among NUM_REQ requesters. It accepts one 4-bit operand at a time over a valid/ready handshake and drives it, registered, into the datapath. After the evaluation window it captures the 38-bit result and returns it with the requester's id over a valid/ready response port. The block sits between the requester-facing fabric and the free-standing arithmetic datapath, which has no clock of its own.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- EVAL_CYCLES, 2: datapath evaluation cycles; used only when DPSEQ_MULTICYCLE_EN is defined; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  4*NUM_REQ  operand of requester i in bits [4i+3:4i].
- req_ready  out  NUM_REQ  one-hot accept strobe, or all zero.
- dp_in_data  out  4  registered operand driven to the datapath.
- dp_out_data  in  38  datapath result; combinational function of dp_in_data.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result consumer ready.
- rsp_data  out  38  captured result.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns rsp_data.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EVAL, RESP.
- **IDLE**
  - If any req_valid is high, grant the first valid requester found by searching upward from last_grant+1 (mod NUM_REQ).
  - req_ready[grant] is high combinationally in this cycle.
  - On the clock edge: dp_in_data ← operand, id_q ← grant, last_grant ← grant, state → EVAL.
  - If no req_valid is high, req_ready = 0 and nothing changes.
- **EVAL**
  - req_ready = 0 and dp_in_data is held.
  - At the end of the window: rsp_data ← dp_out_data, rsp_id ← id_q, state → RESP.
- **RESP**
  - rsp_valid = 1; rsp_data and rsp_id are stable.
  - If rsp_ready is high: state → IDLE at the edge, rsp_valid deasserts.
  - If rsp_ready is low: hold indefinitely.
- Handshake rules:
  - Requesters must hold req_valid and req_data stable until req_ready.
  - req_ready depends on req_valid. req_valid must not depend on req_ready.
  - rsp_valid never drops without rsp_ready.
- Widths: operands are zero-extended by the datapath, not by this block. rsp_data is captured at full 38 bits with no truncation.
- Boundary conditions:
  - Simultaneous requests are granted strictly round-robin, so no requester waits more than NUM_REQ-1 grants.
  - A single persistent requester is granted every transaction.
  - last_grant wraps from NUM_REQ-1 to 0.
  - A request that arrives in the cycle RESP completes is not seen until IDLE, i.e. the next cycle.
  - Asserting rst at any point aborts the in-flight transaction. Nothing is replayed.

## Timing
- Reset values: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), dp_in_data=0, rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0.
- Latency: with the accept edge at cycle 0, rsp_valid is first high in cycle 1+E, where E is the evaluation cycle count (1 by default).
- Throughput with rsp_ready tied high: one transaction per 2+E cycles. There is no overlap between transactions.
- dp_out_data is sampled only at the final EVAL edge, so the datapath gets E full cycles of settling.

## Configuration
- DPSEQ_MULTICYCLE_EN defined:
  - A 4-bit down-counter loads EVAL_CYCLES-1 on entry to EVAL.
  - Capture occurs when the counter is 0, so E = EVAL_CYCLES.
  - The counter resets to 0.
- DPSEQ_MULTICYCLE_EN undefined:
  - No counter is built. EVAL lasts exactly one cycle (E = 1).
  - EVAL_CYCLES is ignored.

## Structure
- Package dp_seq_pkg holds:
  - the state enum (IDLE, EVAL, RESP);
  - DP_IN_W = 4;
  - DP_OUT_W = 38.
- Sub-module dp_seq_rr_arb is the combinational round-robin arbiter.
  - Inputs: req_valid, last_grant.
  - Outputs: one-hot grant, encoded grant index, any_valid.
- The arithmetic datapath is not instantiated inside this block.

## Test plan
The bench models the datapath as dp_out_data = dp_in_data × 3, zero-extended to 38 bits.
- Reset: hold rst for 3 cycles, then release → all outputs at reset values, busy=0, no req_ready.
- Single request: requester 2 presents 4'h5 with rsp_ready=1 → req_ready=4'b0100 in the request cycle; rsp_valid 2 cycles later with rsp_data=38'd15, rsp_id=2; busy drops the following cycle.
- Round-robin: all 4 requesters valid continuously with operands 1,2,3,4 → responses in id order 0,1,2,3,0 with rsp_data 3,6,9,12,3, one every 3 cycles.
- Backpressure: rsp_ready held low for 10 cycles during RESP → rsp_valid, rsp_data and rsp_id stay stable, req_ready=0 throughout; the transaction completes on the first rsp_ready=1 cycle.
- Mid-operation reset: assert rst during EVAL → next cycle rsp_valid=0, dp_in_data=0, busy=0; the next grant goes to requester 0.
- Multicycle: with DPSEQ_MULTICYCLE_EN and EVAL_CYCLES=3, operand 4'hF → rsp_valid 4 cycles after accept with rsp_data=38'd45; a dp_out_data glitch injected in the first EVAL cycle is not captured.
